// File: rtl/pong_vga_pkg.sv
// pong_vga_pkg: 640x480@60 raster constants and axis phase type,
// shared by the timing generator, renderer and game logic.
package pong_vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FRONT  = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BACK   = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FRONT  = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BACK   = 33;

    localparam int VGA_H_TOTAL =
        VGA_H_ACTIVE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int VGA_V_TOTAL =
        VGA_V_ACTIVE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    localparam int VGA_HS_START = VGA_H_ACTIVE + VGA_H_FRONT;
    localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC - 1;
    localparam int VGA_VS_START = VGA_V_ACTIVE + VGA_V_FRONT;
    localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC - 1;

    localparam int VGA_POS_W = 10;
    localparam int VGA_FC_W  = 6;
    localparam int VGA_RGB_W = 6;
    localparam int VGA_BAR_PX = 80;

    typedef enum logic [1:0] {
        ACTIVE,
        FRONT,
        SYNC,
        BACK
    } axis_phase_e;

    // Colour bar k expands each index bit into a 2-bit channel.
    function automatic logic [VGA_RGB_W-1:0] bar_rgb(input logic [2:0] k);
        return {k[2], k[2], k[1], k[1], k[0], k[0]};
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster bundle from the timing generator to the
// renderer. master = generator (drives raster), slave = consumer.
interface vga_timing_gen_if;

    logic                                pix_en;
    logic [pong_vga_pkg::VGA_POS_W-1:0]  hpos;
    logic [pong_vga_pkg::VGA_POS_W-1:0]  vpos;
    logic                                hsync;
    logic                                vsync;
    logic                                display_on;
    logic                                line_start;
    logic                                frame_start;
    logic                                game_tick;
    logic [pong_vga_pkg::VGA_FC_W-1:0]   frame_count;
    logic [pong_vga_pkg::VGA_RGB_W-1:0]  pattern_rgb;

    modport master (
        input  pix_en,
        output hpos, vpos, hsync, vsync, display_on,
        output line_start, frame_start, game_tick,
        output frame_count, pattern_rgb
    );

    modport slave (
        input pix_en, hpos, vpos, hsync, vsync, display_on,
        input line_start, frame_start, game_tick,
        input frame_count, pattern_rgb
    );

endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis. Ports: clk, rst_n, en_i (advance),
// cnt_o/cnt_nx_o (current/next count), wrap_o (last count + en), sync_o.
module vga_axis_counter
    import pong_vga_pkg::*;
#(
    parameter int A_LEN    = VGA_H_ACTIVE,
    parameter int F_LEN    = VGA_H_FRONT,
    parameter int S_LEN    = VGA_H_SYNC,
    parameter int B_LEN    = VGA_H_BACK,
    parameter bit SYNC_POL = 1'b0,
    parameter int W        = VGA_POS_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic [W-1:0] cnt_nx_o,
    output logic         wrap_o,
    output logic         sync_o
);

    localparam int TOTAL = A_LEN + F_LEN + S_LEN + B_LEN;
    localparam logic [W-1:0] LAST_A = W'(A_LEN - 1);
    localparam logic [W-1:0] LAST_F = W'(A_LEN + F_LEN - 1);
    localparam logic [W-1:0] LAST_S = W'(A_LEN + F_LEN + S_LEN - 1);
    localparam logic [W-1:0] LAST   = W'(TOTAL - 1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         wrap;
    axis_phase_e  phase_q;
    logic         sync_q;

    always_comb begin
        wrap  = en_i && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Phase changes on the same edge as the count, so sync_q is
    // already aligned with the count it describes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= ACTIVE;
            sync_q  <= ~SYNC_POL;
        end else if (en_i) begin
            unique case (phase_q)
                ACTIVE: begin
                    if (cnt_q == LAST_A) phase_q <= FRONT;
                end
                FRONT: begin
                    if (cnt_q == LAST_F) begin
                        phase_q <= SYNC;
                        sync_q  <= SYNC_POL;
                    end
                end
                SYNC: begin
                    if (cnt_q == LAST_S) begin
                        phase_q <= BACK;
                        sync_q  <= ~SYNC_POL;
                    end
                end
                BACK: begin
                    if (cnt_q == LAST) phase_q <= ACTIVE;
                end
                default: phase_q <= ACTIVE;
            endcase
        end
    end

    assign cnt_o    = cnt_q;
    assign cnt_nx_o = cnt_d;
    assign wrap_o   = wrap;
    assign sync_o   = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster, sync, strobes and game tick. Ports: clk,
// rst_n, bus (master). Macro VGA_TEST_PATTERN_EN enables colour bars.
module vga_timing_gen
    import pong_vga_pkg::*;
#(
    parameter int H_ACTIVE  = VGA_H_ACTIVE,
    parameter int H_FRONT   = VGA_H_FRONT,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BACK    = VGA_H_BACK,
    parameter int V_ACTIVE  = VGA_V_ACTIVE,
    parameter int V_FRONT   = VGA_V_FRONT,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BACK    = VGA_V_BACK,
    parameter bit SYNC_POL  = 1'b0,
    parameter int FRAME_DIV = 2
) (
    input logic              clk,
    input logic              rst_n,
    vga_timing_gen_if.master bus
);

    localparam int W  = VGA_POS_W;
    localparam int FW = VGA_FC_W;

    logic [W-1:0]  h_q, h_nx, v_q, v_nx;
    logic          h_wrap, v_wrap, hs, vs;
    logic          disp_d, disp_q;
    logic          line_q, frame_q, tick_d, tick_q;
    logic [FW-1:0] fc_d, fc_q;

    vga_axis_counter #(
        .A_LEN(H_ACTIVE), .F_LEN(H_FRONT),
        .S_LEN(H_SYNC), .B_LEN(H_BACK),
        .SYNC_POL(SYNC_POL), .W(W)
    ) u_h (
        .clk(clk), .rst_n(rst_n), .en_i(bus.pix_en),
        .cnt_o(h_q), .cnt_nx_o(h_nx),
        .wrap_o(h_wrap), .sync_o(hs)
    );

    // Vertical axis steps only on the horizontal wrap.
    vga_axis_counter #(
        .A_LEN(V_ACTIVE), .F_LEN(V_FRONT),
        .S_LEN(V_SYNC), .B_LEN(V_BACK),
        .SYNC_POL(SYNC_POL), .W(W)
    ) u_v (
        .clk(clk), .rst_n(rst_n), .en_i(h_wrap),
        .cnt_o(v_q), .cnt_nx_o(v_nx),
        .wrap_o(v_wrap), .sync_o(vs)
    );

    // Flags come from the next counts so they land with the counts.
    // h_wrap/v_wrap already include pix_en, so strobes die on stalls.
    always_comb begin
        disp_d = (h_nx < W'(H_ACTIVE)) && (v_nx < W'(V_ACTIVE));
        fc_d   = fc_q;
        if (v_wrap) begin
            fc_d = (fc_q == FW'(FRAME_DIV - 1)) ? '0 : fc_q + 1'b1;
        end
        tick_d = v_wrap && (fc_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q  <= 1'b0;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
            tick_q  <= 1'b0;
            fc_q    <= '0;
        end else begin
            disp_q  <= disp_d;
            line_q  <= h_wrap;
            frame_q <= v_wrap;
            tick_q  <= tick_d;
            fc_q    <= fc_d;
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0]           bar;
    logic [VGA_RGB_W-1:0] pat_q;

    assign bar = 3'(h_nx / W'(VGA_BAR_PX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q <= '0;
        end else begin
            pat_q <= disp_d ? bar_rgb(bar) : '0;
        end
    end

    assign bus.pattern_rgb = pat_q;
`else
    assign bus.pattern_rgb = '0;
`endif

    assign bus.hpos        = h_q;
    assign bus.vpos        = v_q;
    assign bus.hsync       = hs;
    assign bus.vsync       = vs;
    assign bus.display_on  = disp_q;
    assign bus.line_start  = line_q;
    assign bus.frame_start = frame_q;
    assign bus.game_tick   = tick_q;
    assign bus.frame_count = fc_q;

endmodule
